keypad_matrix_scan: RTL and testbench
=====================================

Name: keypad_matrix_scan

Overview:
- Parameterised successor to the fixed 4x3 lock keypad scanner.
- Drives one-cold column strobes and samples active-low rows through a synchroniser.
- Debounces both press and release, and emits compact scan codes with separate press and release pulses.
- Flags multi-key (ghost) presses instead of decoding them. Sits between the keypad pins and the lock control FSM; digit remapping is done downstream.

Parameters:
- ROWS, 4, number of row inputs (2..8).
- COLS, 3, number of column outputs (2..8).
- DEBOUNCE_MAX, 999_999, debounce window terminal count (20 ms at 50 MHz).
- SETTLE_CYCLES, 4, cycles between a column change and the row sample (>=1).
- REPEAT_DELAY, 24_999_999, cycles from press to first auto-repeat (optional feature only).
- REPEAT_RATE, 4_999_999, cycles between auto-repeats (optional feature only).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- scan_en  in  1  scanning enable; low forces idle
- row  in  ROWS  keypad rows, active-low, externally pulled up
- col  out  COLS  column strobes, one-cold (exactly one bit low while scanning)
- key_flag  out  1  one-cycle press pulse; key_code valid in the same cycle
- rel_flag  out  1  one-cycle release pulse for the held key
- key_code  out  $clog2(ROWS*COLS)  scan code = row_index*COLS + col_index; holds its value until the next press
- key_held  out  1  high from key_flag until rel_flag
- multi_err  out  1  one-cycle pulse when more than one row is low in the strobed column

Behaviour:
- Clock is clk; reset is rst_n, asynchronous, active-low.
- Reset values:
  - col = all ones except bit0 low.
  - key_flag, rel_flag, key_held, multi_err, key_code = 0.
  - FSM in SETTLE; all counters 0.
- row passes through a 2-flop synchroniser. All decisions use the synchronised value rs.
- States:
  - SETTLE: count SETTLE_CYCLES with the current column driven, then go to SAMPLE.
  - SAMPLE: if rs is all ones, rotate col to the next column (wrapping COLS-1 to 0) and go to SETTLE. Otherwise go to FILT0 without rotating.
  - FILT0: debounce counter runs 0..DEBOUNCE_MAX. At the terminal count:
    - rs all ones -> rotate col, go to SETTLE (bounce rejected, no flag).
    - exactly one bit of rs low -> key_flag=1 and key_code loaded for one cycle; key_held set; go to HELD.
    - two or more bits low -> multi_err=1 for one cycle; no key_flag; key_code unchanged; go to HELD.
  - HELD: col frozen. When rs is all ones, go to FILT1.
  - FILT1: debounce counter runs 0..DEBOUNCE_MAX. At the terminal count:
    - rs all ones -> if key_held, rel_flag=1 for one cycle and key_held cleared. Then rotate col and go to SETTLE.
    - rs not all ones -> return to HELD with no flag.
- The debounce counter clears on every state entry. The width is sized to DEBOUNCE_MAX.
- Press latency: key_flag asserts DEBOUNCE_MAX+1 cycles after the SAMPLE cycle that detected the press.
- scan_en low, from any state, on the next clock:
  - col = all ones, FSM to SETTLE on column 0, counters clear.
  - A pending press is abandoned with no flags. If key_held, it clears without rel_flag.
- scan_en rising: scanning restarts at column 0.
- Only one key is tracked at a time. Other keys pressed during HELD are ignored.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined: in HELD, a repeat counter starts at the key_flag cycle.
  - When it reaches REPEAT_DELAY, key_flag pulses again with the unchanged key_code.
  - After that, key_flag pulses every REPEAT_RATE cycles until HELD is left.
  - No repeats follow a multi_err entry.
  - Leaving HELD, including entering FILT1, clears the repeat counter.
- Undefined: exactly one key_flag per press; repeat logic is absent and REPEAT_* are ignored.

Test Plan:
Sim parameters: DEBOUNCE_MAX=15, SETTLE_CYCLES=2, REPEAT_DELAY=40, REPEAT_RATE=10.
- Reset with rows 1111 -> col=110, all flags 0, key_code=0. After release of reset, col rotates 110->101->011->110 with 3 cycles per column.
- row=1011 while col=101 held for 100 cycles -> one key_flag with key_code=7 (row2*3+col1), key_held=1; col frozen at 101.
- Release to 1111 -> rel_flag after DEBOUNCE_MAX+1 cycles, key_held=0, scanning resumes at col=011.
- Press glitch of 8 cycles at col=110 -> no key_flag, scanning continues.
- row=1001 at col=011 -> multi_err pulse, no key_flag, key_code unchanged. After release: no rel_flag.
- With KEYPAD_REPEAT_EN defined, hold key 0 for 80 cycles -> key_flag at press, at +40, +50, +60, +70 and +80 cycles. Drop scan_en mid-hold -> col=111, no rel_flag.

Source files
------------

// File: rtl/keypad_matrix_scan.sv
// -----------------------------------------------------------------------------
// keypad_matrix_scan
//   Row/column keypad scanner. Walks a one-cold strobe across the columns,
//   samples the active-low rows through a 2-flop synchroniser, debounces both
//   press and release, and reports a compact scan code
//   (row_index*COLS + col_index). Two or more rows low in the strobed column
//   is reported as multi_err instead of being decoded.
//
//   Optional auto-repeat: define KEYPAD_REPEAT_EN to re-pulse key_flag after
//   REPEAT_DELAY cycles of hold, then every REPEAT_RATE cycles.
//
// Ports
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   scan_en   in   scanning enable; low parks the scanner (all columns high)
//   row       in   [ROWS]  keypad rows, active-low, pulled up
//   col       out  [COLS]  column strobes, one-cold while scanning
//   key_flag  out  one-cycle press pulse, key_code valid in the same cycle
//   rel_flag  out  one-cycle release pulse for the held key
//   key_code  out  scan code, holds until the next press
//   key_held  out  high from key_flag until rel_flag
//   multi_err out  one-cycle pulse when >1 row is low in the strobed column
// -----------------------------------------------------------------------------
module keypad_matrix_scan #(
    parameter int ROWS          = 4,
    parameter int COLS          = 3,
    parameter int DEBOUNCE_MAX  = 999_999,
    parameter int SETTLE_CYCLES = 4,
    parameter int REPEAT_DELAY  = 24_999_999,
    parameter int REPEAT_RATE   = 4_999_999
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            scan_en,
    input  logic [ROWS-1:0]                 row,
    output logic [COLS-1:0]                 col,
    output logic                            key_flag,
    output logic                            rel_flag,
    output logic [$clog2(ROWS*COLS)-1:0]    key_code,
    output logic                            key_held,
    output logic                            multi_err
);

    localparam int KEY_W   = $clog2(ROWS*COLS);
    localparam int CIDX_W  = $clog2(COLS);
    localparam int RIDX_W  = $clog2(ROWS);
    localparam int CNT_MAX = (DEBOUNCE_MAX > SETTLE_CYCLES) ? DEBOUNCE_MAX : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    if (ROWS < 2 || ROWS > 8 || COLS < 2 || COLS > 8 || SETTLE_CYCLES < 1 ||
        DEBOUNCE_MAX < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
        $error("keypad_matrix_scan: parameter out of range");
    end

    typedef enum logic [2:0] {SETTLE, SAMPLE, FILT0, HELD, FILT1} state_t;
    state_t state, state_nxt;

    logic [ROWS-1:0]   row_s1, rs, rl;
    logic              active;          // low while parked by scan_en
    logic [CIDX_W-1:0] col_idx;
    logic [CNT_W-1:0]  cnt;
    logic [KEY_W-1:0]  code_q, code_new;
    logic              held_q;
    logic [RIDX_W-1:0] row_idx;
    logic              rs_idle, rs_one, st_done, db_done, rotate, press, rpt_fire;

    // ---------------- row decode ----------------
    assign rl      = ~rs;
    assign rs_idle = (rl == '0);
    assign rs_one  = !rs_idle && ((rl & (rl - ROWS'(1))) == '0);
    assign st_done = (cnt == CNT_W'(SETTLE_CYCLES - 1));
    assign db_done = (cnt == CNT_W'(DEBOUNCE_MAX));

    always_comb begin
        row_idx = '0;
        for (int r = 0; r < ROWS; r++)
            if (!rs[r]) row_idx = RIDX_W'(r);
    end

    assign code_new = KEY_W'(row_idx) * KEY_W'(COLS) + KEY_W'(col_idx);

    // Advance to the next column whenever a sample or a debounce window
    // ends with all rows idle.
    assign rotate = rs_idle && ((state == SAMPLE) ||
                                ((state == FILT0 || state == FILT1) && db_done));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SETTLE;
        else        state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            SETTLE:  if (st_done) state_nxt = SAMPLE;
            SAMPLE:  state_nxt = rs_idle ? SETTLE : FILT0;
            FILT0:   if (db_done) state_nxt = rs_idle ? SETTLE : HELD;
            HELD:    if (rs_idle) state_nxt = FILT1;
            FILT1:   if (db_done) state_nxt = rs_idle ? SETTLE : HELD;
            default: state_nxt = SETTLE;
        endcase
        if (!scan_en || !active) state_nxt = SETTLE;
    end

    // ---------------- FSM: outputs ----------------
    // Flags are gated by scan_en so a window ending in the same cycle
    // scan_en drops is abandoned silently.
    always_comb begin
        press     = 1'b0;
        multi_err = 1'b0;
        rel_flag  = 1'b0;
        if (scan_en && active) begin
            case (state)
                FILT0: if (db_done && !rs_idle) begin
                           if (rs_one) press     = 1'b1;
                           else        multi_err = 1'b1;
                       end
                FILT1: if (db_done && rs_idle && held_q) rel_flag = 1'b1;
                default: ;
            endcase
        end
        key_flag = press | rpt_fire;
        key_code = press ? code_new : code_q;
        key_held = held_q | press;
        col      = active ? ~(COLS'(1) << col_idx) : '1;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_s1 <= '1;
            rs     <= '1;
        end else begin
            row_s1 <= row;
            rs     <= row_s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active  <= 1'b1;
            col_idx <= '0;
            cnt     <= '0;
            code_q  <= '0;
            held_q  <= 1'b0;
        end else if (!scan_en) begin
            active  <= 1'b0;
            col_idx <= '0;
            cnt     <= '0;
            held_q  <= 1'b0;
        end else begin
            active <= 1'b1;
            // Counter restarts on every state entry; HELD has no use for it.
            cnt <= (state_nxt != state || state == HELD || !active) ? '0 : cnt + 1'b1;
            if (rotate && active)
                col_idx <= (col_idx == CIDX_W'(COLS - 1)) ? '0 : col_idx + 1'b1;
            if (press) begin
                code_q <= code_new;
                held_q <= 1'b1;
            end
            if (rel_flag) held_q <= 1'b0;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_rate;     // first repeat done, now at REPEAT_RATE

    // held_q is clear after a multi_err entry, which suppresses repeats.
    assign rpt_fire = scan_en && active && (state == HELD) && held_q &&
                      (rpt_cnt == (rpt_rate ? RPT_W'(REPEAT_RATE) : RPT_W'(REPEAT_DELAY)));

    // Counts from the key_flag cycle (value 0) for as long as HELD lasts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt  <= '0;
            rpt_rate <= 1'b0;
        end else if (scan_en && state_nxt == HELD && (state == HELD || press)) begin
            if (rpt_fire) begin
                rpt_cnt  <= RPT_W'(1);
                rpt_rate <= 1'b1;
            end else begin
                rpt_cnt  <= rpt_cnt + 1'b1;
            end
        end else begin
            rpt_cnt  <= '0;
            rpt_rate <= 1'b0;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_matrix_scan.sv
module tb_keypad_matrix_scan;
    localparam int ROWS = 4, COLS = 3;
    localparam int DM = 15, ST = 2, RD = 40, RR = 10;
    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic rst_n, scan_en;
    logic [ROWS-1:0] row;
    logic [COLS-1:0] col;
    logic key_flag, rel_flag, key_held, multi_err;
    logic [3:0] key_code;
    logic [ROWS-1:0][COLS-1:0] pressed;

    int n_vec = 0, n_err = 0;
    int cyc = 0;
    int q_fcyc[$], q_fcode[$], q_rel[$], q_merr[$];
    int chg_into[COLS];
    int chg_cnt = 0;
    logic [COLS-1:0] col_prev = '1;
    int last_code = 0;

    keypad_matrix_scan #(
        .ROWS(ROWS), .COLS(COLS), .DEBOUNCE_MAX(DM), .SETTLE_CYCLES(ST),
        .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .scan_en(scan_en), .row(row), .col(col),
        .key_flag(key_flag), .rel_flag(rel_flag), .key_code(key_code),
        .key_held(key_held), .multi_err(multi_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Physical keypad: a closed switch pulls its row low while its column is strobed.
    always_comb begin
        row = '1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (pressed[r][c] && !col[c]) row[r] = 1'b0;
    end

    function automatic int col2idx(input logic [COLS-1:0] v);
        int n, idx;
        n = 0; idx = -1;
        for (int c = 0; c < COLS; c++) if (!v[c]) begin n++; idx = c; end
        return (n == 1) ? idx : -1;
    endfunction

    function automatic logic [COLS-1:0] strobe(input int c);
        logic [COLS-1:0] s;
        s = '1; s[c] = 1'b0;
        return s;
    endfunction

    // Event recorder, stamped with the posedge count.
    always @(negedge clk) begin
        if (key_flag) begin q_fcyc.push_back(cyc); q_fcode.push_back(int'(key_code)); end
        if (rel_flag) q_rel.push_back(cyc);
        if (multi_err) q_merr.push_back(cyc);
        if (col != col_prev) begin
            chg_cnt <= chg_cnt + 1;
            if (col2idx(col) >= 0) chg_into[col2idx(col)] <= cyc;
        end
        col_prev <= col;
    end

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_vec++;
        if (obs != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic clear_q();
        q_fcyc.delete(); q_fcode.delete(); q_rel.delete(); q_merr.delete();
    endtask

    task automatic wait_idx(input int c, input bit want_eq);
        int n;
        n = 0;
        @(negedge clk);
        while (((col2idx(col) == c) != want_eq) && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("wait_col_timeout", n, 0);
    endtask

    task automatic run_press(input int r, input int c, input int hold, input int xr, input int xc);
        int rel_c, t_in, fe;
        int exp_cyc[$];
        wait_idx(c, 1'b0);
        clear_q();
        pressed[r][c] = 1'b1;
        for (int i = 0; i < hold; i++) begin
            if (xr >= 0 && i == hold / 2) pressed[xr][xc] = 1'b1;
            @(negedge clk);
        end
        chk("held_high", int'(key_held), 1);
        chk("col_frozen", int'(col), int'(strobe(c)));
        t_in  = chg_into[c];
        rel_c = cyc;
        pressed = '0;
        repeat (SYNC + DM + 1 + 2) @(negedge clk);
        fe = t_in + ST + DM + 1;
        exp_cyc.push_back(fe);
`ifdef KEYPAD_REPEAT_EN
        for (int t = fe + RD; t <= rel_c + SYNC; t += RR) exp_cyc.push_back(t);
`endif
        chk("flag_cnt", q_fcyc.size(), exp_cyc.size());
        for (int i = 0; i < exp_cyc.size() && i < q_fcyc.size(); i++) begin
            chk("flag_cyc", q_fcyc[i], exp_cyc[i]);
            chk("flag_code", q_fcode[i], r * COLS + c);
        end
        chk("rel_cnt", q_rel.size(), 1);
        if (q_rel.size() > 0) chk("rel_cyc", q_rel[0], rel_c + SYNC + DM + 1);
        chk("press_merr", q_merr.size(), 0);
        chk("held_low", int'(key_held), 0);
        chk("resume_col", col2idx(col), (c + 1) % COLS);
        last_code = r * COLS + c;
    endtask

    task automatic run_glitch(input int r, input int c, input int g);
        int n0;
        wait_idx(c, 1'b0);
        wait_idx(c, 1'b1);
        clear_q();
        n0 = chg_cnt;
        pressed[r][c] = 1'b1;
        repeat (g) @(negedge clk);
        pressed = '0;
        repeat (40) @(negedge clk);
        chk("glitch_flag", q_fcyc.size(), 0);
        chk("glitch_rel", q_rel.size(), 0);
        chk("glitch_merr", q_merr.size(), 0);
        chk("glitch_scan", int'(chg_cnt - n0 >= 3), 1);
    endtask

    task automatic run_multi(input int r1, input int r2, input int c, input int hold);
        int t_in;
        wait_idx(c, 1'b0);
        clear_q();
        pressed[r1][c] = 1'b1;
        pressed[r2][c] = 1'b1;
        repeat (hold) @(negedge clk);
        chk("multi_held", int'(key_held), 0);
        chk("multi_col", int'(col), int'(strobe(c)));
        t_in = chg_into[c];
        pressed = '0;
        repeat (SYNC + DM + 1 + 2) @(negedge clk);
        chk("merr_cnt", q_merr.size(), 1);
        if (q_merr.size() > 0) chk("merr_cyc", q_merr[0], t_in + ST + DM + 1);
        chk("multi_flag", q_fcyc.size(), 0);
        chk("multi_rel", q_rel.size(), 0);
        chk("multi_code", int'(key_code), last_code);
        chk("multi_resume", col2idx(col), (c + 1) % COLS);
    endtask

    task automatic run_drop(input int r, input int c, input int d);
        int n, drop_c, late;
        wait_idx(c, 1'b0);
        clear_q();
        pressed[r][c] = 1'b1;
        n = 0;
        while (!key_flag && n < 60) begin @(negedge clk); n++; end
        chk("drop_press", int'(key_flag), 1);
        repeat (d) @(negedge clk);
        drop_c = cyc;
        scan_en = 1'b0;
        @(negedge clk);
        chk("drop_col", int'(col), int'({COLS{1'b1}}));
        chk("drop_held", int'(key_held), 0);
        repeat (5) @(negedge clk);
        pressed = '0;
        repeat (30) @(negedge clk);
        chk("drop_rel", q_rel.size(), 0);
        late = 0;
        foreach (q_fcyc[i]) if (q_fcyc[i] > drop_c) late++;
        chk("drop_noflag", late, 0);
        chk("drop_idle_col", int'(col), int'({COLS{1'b1}}));
        scan_en = 1'b1;
        @(negedge clk);
        chk("restart_col", int'(col), int'(strobe(0)));
        n = 0;
        while (col2idx(col) == 0 && n < 20) begin @(negedge clk); n++; end
        chk("restart_period", n, ST + 1);
        chk("restart_next", col2idx(col), 1);
        last_code = r * COLS + c;
    endtask

    initial begin
        logic [COLS-1:0] prev;
        int n, kind, r, c, r2, xr, xc;
        rst_n = 1'b0; scan_en = 1'b1; pressed = '0;
        repeat (3) @(negedge clk);
        chk("rst_col", int'(col), int'(strobe(0)));
        chk("rst_key_flag", int'(key_flag), 0);
        chk("rst_rel_flag", int'(rel_flag), 0);
        chk("rst_held", int'(key_held), 0);
        chk("rst_merr", int'(multi_err), 0);
        chk("rst_code", int'(key_code), 0);
        rst_n = 1'b1;

        // idle rotation
        prev = col;
        for (int k = 1; k <= 4; k++) begin
            n = 0;
            while (col == prev && n < 20) begin @(negedge clk); n++; end
            chk("rot_col", col2idx(col), k % COLS);
            if (k > 1) chk("rot_period", n, ST + 1);
            prev = col;
        end

        run_press(2, 1, 100, -1, 0);   // code 7
        run_glitch(0, 0, 8);
        run_multi(1, 2, 2, 60);
        run_press(0, 0, 90, -1, 0);
        run_drop(0, 0, 50);

        for (int it = 0; it < 24; it++) begin
            kind = $urandom_range(0, 3);
            r = $urandom_range(0, ROWS - 1);
            c = $urandom_range(0, COLS - 1);
            case (kind)
                0: begin
                    xr = ($urandom_range(0, 1) == 1) ? $urandom_range(0, ROWS - 1) : -1;
                    xc = (c + 1 + $urandom_range(0, COLS - 2)) % COLS;
                    run_press(r, c, $urandom_range(40, 120), xr, xc);
                end
                1: run_glitch(r, c, $urandom_range(1, 8));
                2: begin
                    r2 = (r + 1 + $urandom_range(0, ROWS - 2)) % ROWS;
                    run_multi(r, r2, c, $urandom_range(40, 80));
                end
                default: run_drop(r, c, $urandom_range(1, 60));
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
